// File: rtl/spi_xfer_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : spi_xfer_arbiter_pkg                                       |
// | Description : Shared types and defaults for the SPI transfer arbiter:    |
// |               FSM state encoding, default widths and timer sizing.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package spi_xfer_arbiter_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Timer only has to count 0 .. TIMEOUT-1.
  function automatic int timer_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Combinational round-robin picker. Returns the first        |
// |               asserted request searching ptr, ptr+1, ... mod N_REQ.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   req   in  N_REQ  request levels                                        |
// |   ptr   in  PTR_W  highest-priority index                                |
// |   gnt   out N_REQ  one-hot winner (0 when no request)                    |
// |   idx   out PTR_W  winner index                                          |
// |   found out 1      at least one request asserted                         |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  int               j;
  logic [PTR_W-1:0] j_idx;

  // Scan from the lowest priority offset up to offset 0 so the
  // nearest asserted request after ptr is the last one written.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      j_idx = PTR_W'(j);
      if (req[j_idx]) begin
        gnt        = '0;
        gnt[j_idx] = 1'b1;
        idx        = j_idx;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_xfer_arbiter                                           |
// | Description : Shares one full-duplex SPI engine between N_REQ clients.   |
// |               Round-robin grant, TX byte latch, start pulse, wait for    |
// |               done rising edge or timeout, one-cycle response strobe.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset         clock / async active-low reset                      |
// |   req, req_data      client request levels and TX bytes                  |
// |   gnt                one-hot grant, arbitration through response cycle   |
// |   rsp_valid          one-cycle strobe to winner                          |
// |   rsp_data, rsp_err  RX byte (0 unless strobing) and timeout flag        |
// |   spi_start          one-cycle engine start                              |
// |   spi_tx_data        latched TX byte to engine                           |
// |   spi_rx_data        engine RX byte                                      |
// |   spi_done, spi_busy engine status                                       |
// |   arb_busy           arbiter not idle                                    |
// +--------------------------------------------------------------------------+
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic [DATA_W-1:0]       spi_tx_data,
  input  logic [DATA_W-1:0]       spi_rx_data,
  input  logic                    spi_done,
  input  logic                    spi_busy,
  output logic                    arb_busy
);

  localparam int                 PTR_W      = $clog2(N_REQ);
  localparam int                 TIMER_W    = timer_w(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [N_REQ-1:0]   gnt_q;
  logic [DATA_W-1:0]  tx_q;
  logic [DATA_W-1:0]  rx_q;
  logic               err_q;
  logic [TIMER_W-1:0] timer;
  logic               done_q;
  logic               done_qq;
  logic               done_rise;
  logic               timed_out;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_found;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // Only a fresh 0->1 transition counts, so a done level still high
  // from the previous transfer cannot complete the current one.
  assign done_rise = done_q & ~done_qq;
  assign timed_out = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win_idx <= '0;
      gnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      timer   <= '0;
      done_q  <= 1'b0;
      done_qq <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_q  <= spi_done;
      done_qq <= done_q;
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            gnt_q   <= arb_gnt;
            win_idx <= arb_idx;
            tx_q    <= req_data[arb_idx*DATA_W +: DATA_W];
            rx_q    <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_START: timer <= '0;
        ST_WAIT: begin
          timer <= timer + 1'b1;
          // Completion has priority over a coincident timeout.
          if (done_rise) begin
            rx_q  <= spi_rx_data;
            err_q <= 1'b0;
          end else if (timed_out) begin
            rx_q  <= '0;
            err_q <= 1'b1;
          end
        end
        ST_RESP: begin
          gnt_q <= '0;
          ptr   <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    spi_start = 1'b0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    case (state)
      ST_IDLE:  if (arb_found) state_nxt = ST_START;
      ST_START: begin
        spi_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (done_rise || timed_out) state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = gnt_q;
        rsp_data  = rx_q;
        rsp_err   = err_q;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign gnt         = gnt_q;
  assign spi_tx_data = tx_q;
  assign arb_busy    = (state != ST_IDLE);

`ifndef SYNTHESIS
  // Engine sanity: busy must follow a start within 4 cycles.
  // busy_wait counts cycles since start while busy is still low.
  logic [2:0] busy_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                busy_wait <= 3'd0;
    else if (spi_start)        busy_wait <= 3'd1;
    else if (spi_busy)         busy_wait <= 3'd0;
    else if (busy_wait == 3'd4) busy_wait <= 3'd0;
    else if (busy_wait != 3'd0) busy_wait <= busy_wait + 3'd1;
  end

  always @(posedge clk) begin
    assert (!(reset && busy_wait == 3'd4 && !spi_busy))
      else $error("spi_busy did not follow spi_start within 4 cycles");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_xfer_arbiter                                        |
// | Description : Self-checking bench for spi_xfer_arbiter with a simple     |
// |               SPI engine model and a round-robin reference model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_xfer_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           spi_start;
  logic [W-1:0]   spi_tx_data;
  logic [W-1:0]   spi_rx_data = '0;
  logic           spi_done = 1'b0;
  logic           spi_busy = 1'b0;
  logic           arb_busy;

  int n_pass  = 0;
  int n_total = 0;

  spi_xfer_arbiter #(
    .N_REQ   (N),
    .DATA_W  (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_rx_data (spi_rx_data),
    .spi_done    (spi_done),
    .spi_busy    (spi_busy),
    .arb_busy    (arb_busy)
  );

  always #5 clk = ~clk;

  // ---------------- engine model ----------------
  // eng_lat cycles after the start cycle, done rises with eng_next_rx.
  // Pulse mode: done high one cycle. Sticky mode: done stays high until
  // 3 cycles into the next transfer. Dead mode: done never rises.
  int         eng_lat = 8;
  bit         eng_dead = 1'b0;
  bit         eng_sticky = 1'b0;
  logic [W-1:0] eng_next_rx = '0;
  int         eng_cnt = 0;
  int         eng_hold = 0;
  bit         eng_active = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      eng_active  = 1'b0;
      eng_cnt     = 0;
      eng_hold    = 0;
      spi_done    = 1'b0;
      spi_busy    = 1'b0;
      spi_rx_data = '0;
    end else if (spi_start) begin
      eng_active  = 1'b1;
      eng_cnt     = eng_lat;
      eng_hold    = 3;
      spi_busy    = 1'b1;
      spi_rx_data = W'($urandom);
      if (!eng_sticky) spi_done = 1'b0;
    end else if (eng_active) begin
      if (eng_hold > 0) begin
        eng_hold--;
        if (eng_hold == 0) spi_done = 1'b0;
      end
      eng_cnt--;
      if (eng_cnt == 0 && !eng_dead) begin
        spi_done    = 1'b1;
        spi_rx_data = eng_next_rx;
        spi_busy    = 1'b0;
        eng_active  = 1'b0;
      end
    end else if (!eng_sticky) begin
      spi_done = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  int mptr = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One complete transfer. exp_w >= 0 forces the winner from a known
  // scenario; otherwise the round-robin model chooses it.
  task automatic serve(input int exp_w, input bit drop, input bit exp_err);
    int           w;
    int           n;
    bit           leak;
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    w  = (exp_w >= 0) ? exp_w : pick(req, mptr);
    tx = req_data[w*W +: W];
    rx = exp_err ? '0 : eng_next_rx;
    n  = 0;
    while (spi_start !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(spi_start), 1);
    check("gnt_at_start", 32'(gnt), 32'(1 << w));
    check("tx_data", 32'(spi_tx_data), 32'(tx));
    check("arb_busy", 32'(arb_busy), 1);
    // Changing the winner's byte after the grant must have no effect.
    req_data[w*W +: W] = ~tx;
    n    = 0;
    leak = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid == '0 && rsp_data != '0) leak = 1'b1;
    end while (rsp_valid == '0 && n < TO + 16);
    check("rsp_valid", 32'(rsp_valid), 32'(1 << w));
    check("rsp_data", 32'(rsp_data), 32'(rx));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("gnt_in_resp", 32'(gnt), 32'(1 << w));
    check("tx_stable", 32'(spi_tx_data), 32'(tx));
    check("latency", n, exp_err ? TO + 1 : eng_lat + 2);
    check("rsp_data_zero_when_idle", 32'(leak), 0);
    req_data[w*W +: W] = tx;
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    check("gnt_release", 32'(gnt), 0);
    check("rsp_one_cycle", 32'(rsp_valid), 0);
    check("rsp_data_after", 32'(rsp_data), 0);
    check("idle_after", 32'(arb_busy), 0);
    mptr = (w + 1) % N;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mptr = 0;
  endtask

  initial begin
    logic [N-1:0] r;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_spi_start", 32'(spi_start), 0);
    check("rst_tx_data", 32'(spi_tx_data), 0);
    check("rst_arb_busy", 32'(arb_busy), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: single requester 0, A5 out, 3C back
    req_data[0 +: W] = 8'hA5;
    eng_next_rx      = 8'h3C;
    eng_lat          = 8;
    req              = 4'b0001;
    serve(0, 1'b1, 1'b0);

    // 2: all four held, grant order 0,1,2,3,0
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eng_next_rx = W'($urandom);
      eng_lat     = $urandom_range(2, 10);
      serve(i % N, 1'b0, 1'b0);
    end
    req = '0;

    // 3: move ptr to 3, then 3 and 0 together -> 3 first, then 0
    eng_lat = 6;
    req     = 4'b0100;
    eng_next_rx = 8'h5A;
    serve(2, 1'b1, 1'b0);
    req = 4'b1001;
    eng_next_rx = 8'hC3;
    serve(3, 1'b1, 1'b0);
    eng_next_rx = 8'h96;
    serve(0, 1'b1, 1'b0);

    // 4: engine never finishes -> timeout error, then normal transfer
    eng_dead = 1'b1;
    req      = 4'b0100;
    serve(2, 1'b1, 1'b1);
    eng_dead         = 1'b0;
    req_data[W +: W] = 8'h55;
    eng_next_rx      = 8'hF0;
    eng_lat          = 7;
    req              = 4'b0010;
    serve(1, 1'b1, 1'b0);

    // 5: done left high from previous transfer
    eng_sticky  = 1'b1;
    eng_lat     = 8;
    eng_next_rx = 8'h81;
    req         = 4'b0001;
    serve(0, 1'b1, 1'b0);
    eng_next_rx = 8'h7E;
    req         = 4'b0100;
    serve(2, 1'b1, 1'b0);
    eng_sticky = 1'b0;
    @(negedge clk);

    // 6: reset during WAIT
    req_data[W +: W] = 8'h77;
    eng_lat          = 20;
    req              = 4'b0010;
    begin
      int n;
      n = 0;
      while (spi_start !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_spi_start", 32'(spi_start), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_arb_busy", 32'(arb_busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    mptr        = 0;
    eng_lat     = 6;
    eng_next_rx = 8'hB4;
    serve(1, 1'b1, 1'b0);

    // Randomized traffic against the round-robin model
    for (int i = 0; i < 40; i++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      req = req | r;
      for (int k = 0; k < N; k++) req_data[k*W +: W] = W'($urandom);
      eng_lat     = $urandom_range(2, 12);
      eng_next_rx = W'($urandom);
      serve(-1, 1'($urandom_range(0, 1)), 1'b0);
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
